// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 4-stage pipeline. It stalls on load-use hazards, flushes on
// taken branches, holds ID while the multi-cycle mul/div unit runs, and freezes on HALT.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [3:0]        id_funccode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              md_start,
  output logic              md_op,
  output logic              md_abort,
  output logic              md_busy,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Sized for the longer of the two latencies so either reload value fits.
  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned MdCntW    = $clog2(MaxCycles) + 1;

  typedef enum logic [1:0] {StRun, StMdWait, StHalt} state_e;

  state_e              state_q, state_d;
  logic [MdCntW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic is_mul, is_div, is_load_op, is_halt, uses_rt, load_use;

  // Decode of the instruction sitting in ID.
  always_comb begin
    is_mul     = (id_opcode == 4'd0) && (id_funccode == 4'd4);
    is_div     = (id_opcode == 4'd0) && (id_funccode == 4'd5);
    is_load_op = (id_opcode == 4'd8);
    is_halt    = (id_opcode == 4'd15);
    uses_rt    = (id_opcode == 4'd0) || (id_opcode == 4'd11) ||
                 (id_opcode == 4'd4) || (id_opcode == 4'd5) || (id_opcode == 4'd6);
    load_use   = id_valid && ex_memread && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));
  end

  // Next-state and pipeline enables; priority is branch > halt > load-use > mul/div issue.
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;
    md_op       = 1'b0;
    md_abort    = 1'b0;
    md_busy     = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid && is_halt) begin
          state_d = StHalt;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid && (is_mul || is_div)) begin
          md_start    = 1'b1;
          md_op       = is_div;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          md_cnt_d    = is_div ? MdCntW'(DIV_CYCLES - 1) : MdCntW'(MUL_CYCLES - 1);
          // A single-cycle unit needs no wait state: the op enters EX next cycle.
          if ((is_div ? DIV_CYCLES : MUL_CYCLES) > 1) state_d = StMdWait;
        end
      end
      StMdWait: begin
        md_busy = 1'b1;
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          md_abort    = 1'b1;
          md_cnt_d    = '0;
          state_d     = StRun;
        end else if (md_cnt_q != '0) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          md_cnt_d    = md_cnt_q - 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StHalt: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = StRun;
    endcase
  end

  // Saturating count of cycles where the PC was held outside HALT.
  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (state_q != StHalt) && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;

  // State, mul/div countdown and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      md_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with default parameters.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_opcode, id_funccode;
  logic [3:0]  id_rs, id_rt, ex_rd;
  logic        ex_memread, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        md_start, md_op, md_abort, md_busy, halted;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_funccode    (id_funccode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .md_start       (md_start),
    .md_op          (md_op),
    .md_abort       (md_abort),
    .md_busy        (md_busy),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then leave time for new inputs before sampling.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [3:0] fn,
                        input logic [3:0] rs, input logic [3:0] rt);
    id_valid = v; id_opcode = op; id_funccode = fn; id_rs = rs; id_rt = rt;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    ex_memread = 1'b0; ex_rd = 4'd0; ex_branch_taken = 1'b0;

    // 1: reset values
    #3;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_md", {md_start, md_op, md_abort, md_busy, halted}, 0);
    chk("rst_stall", stall_cycles, 0);
    #9 rst_n = 1'b1;

    // 2: load-use on rs, then ex_rd=0 gives no stall
    next_cycle();
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 4'd1); ex_memread = 1'b1; ex_rd = 4'd3; #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_bubble", idex_bubble, 1);
    next_cycle();
    ex_memread = 1'b0; #1;
    chk("lu_release_pc", pc_write, 1);
    chk("lu_release_bubble", idex_bubble, 0);
    chk("lu_stall_cnt", stall_cycles, 1);
    ex_memread = 1'b1; ex_rd = 4'd0; set_id(1'b1, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("lu_rd0_pc", pc_write, 1);
    chk("lu_rd0_bubble", idex_bubble, 0);

    // 3: multiply, 3 busy cycles, enters EX on the third; 1 + 3 stalls total
    next_cycle();
    ex_memread = 1'b0; ex_rd = 4'd0; set_id(1'b1, 4'd0, 4'd4, 4'd1, 4'd2); #1;
    chk("mul_start", md_start, 1);
    chk("mul_op", md_op, 0);
    chk("mul_issue_pc", pc_write, 0);
    chk("mul_issue_bubble", idex_bubble, 1);
    next_cycle();
    chk("mul_busy1", {md_busy, idex_bubble, pc_write, md_start}, 4'b1100);
    next_cycle();
    chk("mul_busy2", {md_busy, idex_bubble, pc_write, md_start}, 4'b1100);
    next_cycle();
    chk("mul_busy3", {md_busy, idex_bubble, pc_write, ifid_write}, 4'b1011);
    next_cycle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("mul_done_busy", md_busy, 0);
    chk("mul_stall_cnt", stall_cycles, 4);

    // 4: divide aborted by a branch on its second busy cycle
    set_id(1'b1, 4'd0, 4'd5, 4'd1, 4'd2); #1;
    chk("div_start", {md_start, md_op}, 2'b11);
    next_cycle();
    chk("div_busy1", md_busy, 1);
    next_cycle();
    ex_branch_taken = 1'b1; #1;
    chk("div_abort", md_abort, 1);
    chk("div_abort_flush", ifid_flush, 1);
    chk("div_abort_bubble", idex_bubble, 1);
    chk("div_abort_pc", pc_write, 1);
    next_cycle();
    ex_branch_taken = 1'b0; set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("div_run_after_abort", {md_busy, md_abort, pc_write}, 3'b001);
    chk("div_stall_cnt", stall_cycles, 6);

    // Store uses rt; opcode 1 does not
    set_id(1'b1, 4'd11, 4'd0, 4'd2, 4'd5); ex_memread = 1'b1; ex_rd = 4'd5; #1;
    chk("lu_store_rt", idex_bubble, 1);
    next_cycle();
    set_id(1'b1, 4'd1, 4'd0, 4'd2, 4'd5); #1;
    chk("lu_op1_rt_ignored", {idex_bubble, pc_write}, 2'b01);
    chk("lu_store_stall_cnt", stall_cycles, 7);
    ex_memread = 1'b0; ex_rd = 4'd0;

    // 5: HALT under a branch is flushed; plain HALT freezes from the next cycle
    set_id(1'b1, 4'd15, 4'd0, 4'd0, 4'd0); ex_branch_taken = 1'b1; #1;
    chk("halt_br_flush", ifid_flush, 1);
    next_cycle();
    ex_branch_taken = 1'b0; set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("halt_br_nohalt", {halted, pc_write}, 2'b01);
    set_id(1'b1, 4'd15, 4'd0, 4'd0, 4'd0); #1;
    chk("halt_same_cycle", halted, 0);
    next_cycle();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("halt_frozen", {halted, pc_write, ifid_write, idex_bubble}, 4'b1001);
    ex_branch_taken = 1'b1; #1;
    chk("halt_ignores_branch", {halted, ifid_flush}, 2'b10);
    next_cycle();
    next_cycle();
    ex_branch_taken = 1'b0; #1;
    chk("halt_still", halted, 1);
    chk("halt_no_stall_count", stall_cycles, 7);

    // 6: counter saturation, then reset in the middle of a divide
    rst_n = 1'b0; #1;
    chk("rst_leaves_halt", halted, 0);
    rst_n = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 4'd0); ex_memread = 1'b1; ex_rd = 4'd3;
    repeat (65541) @(posedge clk);
    #1;
    chk("stall_saturated", stall_cycles, 16'hFFFF);
    next_cycle();
    chk("stall_hold", stall_cycles, 16'hFFFF);
    ex_memread = 1'b0; ex_rd = 4'd0; set_id(1'b1, 4'd0, 4'd5, 4'd1, 4'd2); #1;
    chk("div2_start", md_start, 1);
    next_cycle();
    next_cycle();
    chk("div2_busy", md_busy, 1);
    rst_n = 1'b0; set_id(1'b0, 4'd0, 4'd0, 4'd0, 4'd0); #1;
    chk("rst_mid_div", {md_busy, md_abort, pc_write, ifid_write}, 4'b0011);
    chk("rst_mid_div_cnt", stall_cycles, 0);
    #3 rst_n = 1'b1;
    next_cycle();
    chk("after_rst_run", {md_busy, halted, pc_write}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
